// File: rtl/dla_demux_n.sv
// Config-driven 1:NUM_OUTPUTS stream demux with a single registered output stage.
// Define DLA_DEMUX_N_BROADCAST_EN to treat the all-ones select as a broadcast to every output.
module dla_demux_n #(
  parameter int CONFIG_WIDTH = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_OUTPUTS  = 4,
  parameter int SEL_WIDTH    = $clog2(NUM_OUTPUTS) + 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk_dla,
  input  logic                    i_areset,
  input  logic [CONFIG_WIDTH-1:0] i_config_data,
  input  logic                    i_config_valid,
  output logic                    o_config_ready,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_transmitter_done,
  input  logic [NUM_OUTPUTS-1:0]  i_ready,
  output logic [NUM_OUTPUTS-1:0]  o_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_active,
  output logic                    o_sel_error
);

  typedef enum logic [1:0] {CFG_SEL, CFG_CNT, ACTIVE} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               rst_sync;
  logic                     rst;
  logic [SEL_WIDTH-1:0]     sel_q;
  logic [COUNT_WIDTH-1:0]   cnt_q;
  logic [COUNT_WIDTH-1:0]   beats_q;
  logic                     sel_err_q;
  logic [NUM_OUTPUTS-1:0]   valid_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [NUM_OUTPUTS-1:0]   load_mask;
  logic                     active;
  logic                     sel_bad;
  logic                     reg_free;
  logic                     cfg_take;
  logic                     beat_take;
  logic                     last_beat;
  logic                     unused_cfg;

  function automatic logic sel_out_of_range(input logic [SEL_WIDTH-1:0] s);
`ifdef DLA_DEMUX_N_BROADCAST_EN
    return (s >= SEL_WIDTH'(NUM_OUTPUTS)) && (s != {SEL_WIDTH{1'b1}});
`else
    return s >= SEL_WIDTH'(NUM_OUTPUTS);
`endif
  endfunction

  // Reset asserts asynchronously and releases only after three clean clock edges.
  always_ff @(posedge clk_dla or posedge i_areset) begin
    if (i_areset) rst_sync <= '1;
    else          rst_sync <= {rst_sync[1:0], 1'b0};
  end
  assign rst = rst_sync[2];

  assign active         = (state_q == ACTIVE);
  assign sel_bad        = sel_out_of_range(sel_q);
  assign reg_free       = ~|(valid_q & ~i_ready);
  assign o_ready        = active & (sel_bad | reg_free);
  assign o_config_ready = ~active & ~rst;
  assign cfg_take       = i_config_valid & o_config_ready;
  assign beat_take      = i_valid & o_ready;
  assign last_beat      = beat_take && (cnt_q != '0) && (beats_q == cnt_q - COUNT_WIDTH'(1));
  assign unused_cfg     = ^i_config_data;

  always_comb begin
    load_mask = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      load_mask[i] = (sel_q == SEL_WIDTH'(i));
    end
`ifdef DLA_DEMUX_N_BROADCAST_EN
    if (sel_q == {SEL_WIDTH{1'b1}}) load_mask = '1;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CFG_SEL: if (cfg_take) state_d = CFG_CNT;
      CFG_CNT: if (cfg_take) state_d = ACTIVE;
      ACTIVE:  if (last_beat || i_transmitter_done) state_d = CFG_SEL;
      default: state_d = CFG_SEL;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_dla or posedge rst) begin
    if (rst) state_q <= CFG_SEL;
    else     state_q <= state_d;
  end

  // NOTE: the payload register is reset too, so o_data reads 0 rather than stale data after reset.
  always_ff @(posedge clk_dla or posedge rst) begin
    if (rst) begin
      sel_q     <= '0;
      cnt_q     <= '0;
      beats_q   <= '0;
      sel_err_q <= 1'b0;
      valid_q   <= '0;
      data_q    <= '0;
    end else begin
      if (cfg_take && state_q == CFG_SEL) begin
        sel_q <= i_config_data[SEL_WIDTH-1:0];
        if (sel_out_of_range(i_config_data[SEL_WIDTH-1:0])) sel_err_q <= 1'b1;
      end
      if (cfg_take && state_q == CFG_CNT) begin
        cnt_q   <= i_config_data[COUNT_WIDTH-1:0];
        beats_q <= '0;
      end
      if (beat_take) beats_q <= beats_q + COUNT_WIDTH'(1);

      // Sunk selects still advance the beat count but never touch the output register.
      if (beat_take && !sel_bad) begin
        valid_q <= load_mask;
        data_q  <= i_data;
      end else begin
`ifdef DLA_DEMUX_N_BROADCAST_EN
        valid_q <= valid_q & ~i_ready;
`else
        if (reg_free) valid_q <= '0;
`endif
      end
    end
  end

  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_active    = active;
  assign o_sel_error = sel_err_q;

endmodule

// File: tb/tb_dla_demux_n.sv
// Self-checking bench for dla_demux_n: per-port scoreboard of expected beats plus directed checks.
module tb_dla_demux_n;
  localparam int NO = 4;
  localparam int DW = 32;
  localparam int CW = 32;

  typedef struct {
    int              port;
    logic [DW-1:0]   data;
  } exp_t;

  logic              clk_dla = 1'b0;
  logic              i_areset = 1'b1;
  logic [CW-1:0]     i_config_data = '0;
  logic              i_config_valid = 1'b0;
  logic              o_config_ready;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [DW-1:0]     i_data = '0;
  logic              i_transmitter_done = 1'b0;
  wire  [NO-1:0]     i_ready;
  logic [NO-1:0]     o_valid;
  logic [DW-1:0]     o_data;
  logic              o_active;
  logic              o_sel_error;

  int                n_cmp = 0;
  int                n_err = 0;
  exp_t              exp_q[$];
  int                pops[NO];
  int                idx;
  int                cyc = 0;
  int                base;
  logic [3:0]        tog_pat = 4'b1001;
  logic              tog_en = 1'b0;
  logic [NO-1:0]     rdy_fixed = '1;
  logic [NO-1:0]     prev_stall = '0;
  logic [DW-1:0]     prev_data = '0;

  dla_demux_n dut (
    .clk_dla            (clk_dla),
    .i_areset           (i_areset),
    .i_config_data      (i_config_data),
    .i_config_valid     (i_config_valid),
    .o_config_ready     (o_config_ready),
    .i_valid            (i_valid),
    .o_ready            (o_ready),
    .i_data             (i_data),
    .i_transmitter_done (i_transmitter_done),
    .i_ready            (i_ready),
    .o_valid            (o_valid),
    .o_data             (o_data),
    .o_active           (o_active),
    .o_sel_error        (o_sel_error)
  );

  always #5 clk_dla = ~clk_dla;
  always @(posedge clk_dla) cyc <= cyc + 1;

  // Output 1 follows a 1,0,0,1 ready pattern when toggling is enabled.
  assign i_ready = tog_en ? {rdy_fixed[3:2], tog_pat[cyc[1:0]], rdy_fixed[0]} : rdy_fixed;

  initial for (int i = 0; i < NO; i++) pops[i] = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_dla);
    #1;
  endtask

  task automatic cfg_word(input logic [CW-1:0] d);
    int n;
    n = 0;
    i_config_data  = d;
    i_config_valid = 1'b1;
    while (!o_config_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("cfg_timeout", o_config_ready, 1);
    tick();
    i_config_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input int port);
    int n;
    n = 0;
    i_data  = d;
    i_valid = 1'b1;
    if (port >= 0) exp_q.push_back('{port: port, data: d});
    while (!o_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("beat_timeout", o_ready, 1);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Monitor: handshakes are predicted from values that stay stable up to the next rising edge.
  always @(negedge clk_dla) begin
    if (i_areset) begin
      prev_stall <= '0;
    end else begin
      if (prev_stall != '0) begin
        check("hold_valid", o_valid & prev_stall, prev_stall);
        check("hold_data", o_data, prev_data);
      end
`ifndef DLA_DEMUX_N_BROADCAST_EN
      if (o_valid != '0) check("onehot", $countones(o_valid), 1);
`endif
      for (int i = 0; i < NO; i++) begin
        if (o_valid[i] && i_ready[i]) begin
          idx = -1;
          for (int k = 0; k < exp_q.size(); k++) begin
            if (idx < 0 && exp_q[k].port == i) idx = k;
          end
          if (idx < 0) begin
            check("unexpected_port", i, NO);
          end else begin
            check("data", o_data, exp_q[idx].data);
            exp_q.delete(idx);
            pops[i] <= pops[i] + 1;
          end
        end
      end
      prev_stall <= o_valid & ~i_ready;
      prev_data  <= o_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    i_areset = 1'b0;
    repeat (5) tick();
    check("rst_valid", o_valid, 0);
    check("rst_active", o_active, 0);
    check("rst_sel_error", o_sel_error, 0);
    check("rst_cfg_ready", o_config_ready, 1);
    check("rst_ready", o_ready, 0);

    // sel=2, cnt=3: one beat per cycle with latency 1
    cfg_word(32'd2);
    cfg_word(32'd3);
    for (int b = 0; b < 3; b++) begin
      send_beat(32'hA + b, 2);
      check("t1_valid", o_valid, 4'b0100);
      check("t1_data", o_data, 32'hA + b);
    end
    check("t1_active", o_active, 0);
    check("t1_cfg_ready", o_config_ready, 1);

    // sel=1, cnt=4 with a stalling downstream
    base = pops[1];
    tog_en = 1'b1;
    cfg_word(32'd1);
    cfg_word(32'd4);
    for (int b = 0; b < 4; b++) send_beat(32'h1000 + b, 1);
    check("t2_active", o_active, 0);
    wait_drain();
    check("t2_count", pops[1] - base, 4);
    tog_en = 1'b0;

    // sel=0, cnt=0: unbounded until transmitter done
    base = pops[0];
    cfg_word(32'd0);
    cfg_word(32'd0);
    for (int b = 0; b < 10; b++) send_beat(32'h100 + b, 0);
    check("t3_still_active", o_active, 1);
    i_transmitter_done = 1'b1;
    tick();
    i_transmitter_done = 1'b0;
    check("t3_active", o_active, 0);
    check("t3_cfg_ready", o_config_ready, 1);
    i_valid = 1'b1;
    i_data  = 32'h55;
    for (int c = 0; c < 3; c++) begin
      check("t3_ready_low", o_ready, 0);
      tick();
    end
    i_valid = 1'b0;
    wait_drain();
    check("t3_count", pops[0] - base, 10);

    // sel=5 is out of range: sunk at full rate and flagged
    cfg_word(32'd5);
    check("t4_sel_error", o_sel_error, 1);
    cfg_word(32'd2);
    for (int b = 0; b < 2; b++) begin
      check("t4_ready", o_ready, 1);
      send_beat(32'hBAD0 + b, -1);
      check("t4_valid", o_valid, 0);
    end
    check("t4_active", o_active, 0);

    // Reset in the middle of ACTIVE with output 3 stalled
    rdy_fixed = 4'b0111;
    cfg_word(32'd3);
    cfg_word(32'd5);
    send_beat(32'hDEAD, -1);
    tick();
    check("t5_stalled", o_valid, 4'b1000);
    i_areset = 1'b1;
    #1;
    check("t5_valid_rst", o_valid, 0);
    check("t5_active_rst", o_active, 0);
    repeat (2) tick();
    i_areset = 1'b0;
    rdy_fixed = '1;
    repeat (5) tick();
    check("t5_cfg_ready", o_config_ready, 1);
    check("t5_sel_error", o_sel_error, 0);
    check("t5_valid", o_valid, 0);

`ifdef DLA_DEMUX_N_BROADCAST_EN
    // Broadcast: outputs 0,1 accept first, then 2,3
    rdy_fixed = 4'b0011;
    cfg_word(32'd7);
    check("t6_sel_error", o_sel_error, 0);
    cfg_word(32'd1);
    for (int p = 0; p < NO; p++) exp_q.push_back('{port: p, data: 32'hB0});
    send_beat(32'hB0, -1);
    check("t6_valid_all", o_valid, 4'b1111);
    tick();
    check("t6_valid_hi", o_valid, 4'b1100);
    rdy_fixed = 4'b1100;
    tick();
    check("t6_valid_none", o_valid, 0);
    check("t6_active", o_active, 0);
    rdy_fixed = '1;
`endif

    wait_drain();
    check("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
